// File: rtl/zx_screen_fetch.sv
// rtl/zx_screen_fetch.sv - Spectrum screen RAM reader producing 2x-scaled RGB with border
// Optional attribute flash support is enabled by defining ZX_FLASH_EN.
module zx_screen_fetch #(
  parameter int X0 = 64,
  parameter int Y0 = 48
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        de,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [2:0]  border,
  output logic [12:0] video_addr,
  input  logic [7:0]  video_dout,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        de_o
);

  logic [11:0] fx;
  logic [11:0] fy;
  logic [11:0] dx;
  logic        fetch_win;
  logic        act_win;
  logic [7:0]  sy;
  logic [4:0]  col;
  logic [3:0]  ph;

  logic [7:0]  nxt_bmp;
  logic [7:0]  nxt_att;
  logic [7:0]  cur_bmp;
  logic [7:0]  cur_att;
  logic        flash_ph;

  // Negative offsets wrap to large unsigned values, so one compare bounds each window.
  assign fx        = {2'b00, pix_x} - 12'(X0 - 16);
  assign fy        = {2'b00, pix_y} - 12'(Y0);
  assign dx        = {2'b00, pix_x} - 12'(X0);
  assign fetch_win = de && (fx < 12'd512) && (fy < 12'd384);
  assign act_win   = de && (dx < 12'd512) && (fy < 12'd384);
  assign sy        = fy[8:1];
  assign col       = fx[8:4];
  assign ph        = fx[3:0];

  always_comb begin
    video_addr = 13'h0000;
    if (fetch_win) begin
      case (ph)
        4'd0:    video_addr = {sy[7:6], sy[2:0], sy[5:3], col};
        4'd1:    video_addr = 13'h1800 + {3'b000, sy[7:3], col};
        default: video_addr = 13'h0000;
      endcase
    end
  end

  // The next cell is staged in nxt_* and swapped in on the last pixel of the current cell.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nxt_bmp <= 8'h00;
      nxt_att <= 8'h00;
      cur_bmp <= 8'h00;
      cur_att <= 8'h00;
    end else if (fetch_win) begin
      case (ph)
        4'd1:  nxt_bmp <= video_dout;
        4'd2:  nxt_att <= video_dout;
        4'd15: begin
          cur_bmp <= nxt_bmp;
          cur_att <= nxt_att;
        end
        default: ;
      endcase
    end
  end

`ifdef ZX_FLASH_EN
  logic [4:0] frame_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= 5'd0;
    end else if (pix_x == 10'd0 && pix_y == 10'd0) begin
      frame_cnt <= frame_cnt + 5'd1;
    end
  end

  assign flash_ph = frame_cnt[4];
`else
  assign flash_ph = 1'b0;
`endif

  logic       pix_bit;
  logic       swap;
  logic [2:0] idx;
  logic [7:0] level;

  always_comb begin
    pix_bit = cur_bmp[3'd7 - dx[3:1]];
    swap    = cur_att[7] & flash_ph;
    idx     = 3'b000;
    level   = 8'h00;
    if (act_win) begin
      idx   = (pix_bit ^ swap) ? cur_att[2:0] : cur_att[5:3];
      level = cur_att[6] ? 8'hFF : 8'hD7;
    end else if (de) begin
      idx   = border;
      level = 8'hD7;
    end
  end

  // Colour index bits are {G,R,B}.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r    <= 8'h00;
      g    <= 8'h00;
      b    <= 8'h00;
      de_o <= 1'b0;
    end else begin
      r    <= idx[1] ? level : 8'h00;
      g    <= idx[2] ? level : 8'h00;
      b    <= idx[0] ? level : 8'h00;
      de_o <= de;
    end
  end

endmodule

// File: tb/tb_zx_screen_fetch.sv
// tb/tb_zx_screen_fetch.sv - directed table-driven bench for zx_screen_fetch
module tb_zx_screen_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        de = 1'b0;
  logic [9:0]  pix_x = 10'd0;
  logic [9:0]  pix_y = 10'd0;
  logic [2:0]  border = 3'b000;
  logic [12:0] video_addr;
  logic [7:0]  video_dout = 8'h00;
  logic [7:0]  r, g, b;
  logic        de_o;

  logic [7:0]  mem [0:8191];

  int n_cmp = 0;
  int n_err = 0;

`ifdef ZX_FLASH_EN
  localparam logic [7:0] FLASHED = 8'h00;
`else
  localparam logic [7:0] FLASHED = 8'hD7;
`endif

  zx_screen_fetch #(.X0(64), .Y0(48)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .de         (de),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .border     (border),
    .video_addr (video_addr),
    .video_dout (video_dout),
    .r          (r),
    .g          (g),
    .b          (b),
    .de_o       (de_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) video_dout <= mem[video_addr];

  typedef struct {
    int         y;
    int         x;
    logic       dv;
    logic [2:0] brd;
    logic [7:0] er;
    logic [7:0] eg;
    logic [7:0] eb;
    logic       ede;
    string      name;
  } vec_t;

  vec_t vt [15];

  task automatic step(input int y, input int x, input logic dv);
    pix_y = 10'(y);
    pix_x = 10'(x);
    de    = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic scan_to(input int y, input int x, input logic dv, input logic [2:0] brd);
    border = brd;
    for (int i = 0; i < x; i++) step(y, i, 1'b1);
    step(y, x, dv);
  endtask

  task automatic chk(input string name, input logic [7:0] er, input logic [7:0] eg,
                     input logic [7:0] eb, input logic ede);
    n_cmp++;
    if (r !== er || g !== eg || b !== eb || de_o !== ede) begin
      n_err++;
      $display("FAIL %s: got r=%h g=%h b=%h de_o=%b, want r=%h g=%h b=%h de_o=%b",
               name, r, g, b, de_o, er, eg, eb, ede);
    end
  endtask

  task automatic chk_addr(input string name, input logic [12:0] exp_a);
    n_cmp++;
    if (video_addr !== exp_a) begin
      n_err++;
      $display("FAIL %s: got video_addr=%h, want %h", name, video_addr, exp_a);
    end
  endtask

  task automatic frames(input int n);
    border = 3'b000;
    for (int i = 0; i < n; i++) step(0, 0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h0000] = 8'h80;  mem[13'h1800] = 8'h47;
    mem[13'h001F] = 8'h01;  mem[13'h181F] = 8'h38;
    mem[13'h0020] = 8'hFF;  mem[13'h1820] = 8'h87;
    mem[13'h000E] = 8'hFF;  mem[13'h180E] = 8'h47;
    mem[13'h0010] = 8'hAA;  mem[13'h1810] = 8'h47;

    vt[0]  = '{48,  64,  1'b1, 3'b010, 8'hFF, 8'hFF, 8'hFF, 1'b1, "ink_x64"};
    vt[1]  = '{48,  65,  1'b1, 3'b010, 8'hFF, 8'hFF, 8'hFF, 1'b1, "ink_x65"};
    vt[2]  = '{48,  66,  1'b1, 3'b010, 8'h00, 8'h00, 8'h00, 1'b1, "paper_x66"};
    vt[3]  = '{49,  64,  1'b1, 3'b010, 8'hFF, 8'hFF, 8'hFF, 1'b1, "row49_x64"};
    vt[4]  = '{10,  5,   1'b1, 3'b010, 8'hD7, 8'h00, 8'h00, 1'b1, "border_red"};
    vt[5]  = '{10,  5,   1'b0, 3'b010, 8'h00, 8'h00, 8'h00, 1'b0, "de_low"};
    vt[6]  = '{48,  574, 1'b1, 3'b010, 8'h00, 8'h00, 8'h00, 1'b1, "edge_x574"};
    vt[7]  = '{48,  575, 1'b1, 3'b010, 8'h00, 8'h00, 8'h00, 1'b1, "edge_x575"};
    vt[8]  = '{48,  576, 1'b1, 3'b010, 8'hD7, 8'h00, 8'h00, 1'b1, "edge_x576"};
    vt[9]  = '{48,  572, 1'b1, 3'b010, 8'hD7, 8'hD7, 8'hD7, 1'b1, "edge_paper_x572"};
    vt[10] = '{48,  63,  1'b1, 3'b010, 8'hD7, 8'h00, 8'h00, 1'b1, "left_x63"};
    vt[11] = '{431, 100, 1'b1, 3'b111, 8'h00, 8'h00, 8'h00, 1'b1, "last_row"};
    vt[12] = '{432, 100, 1'b1, 3'b111, 8'hD7, 8'hD7, 8'hD7, 1'b1, "below_window"};
    vt[13] = '{0,   1,   1'b1, 3'b101, 8'h00, 8'hD7, 8'hD7, 1'b1, "top_gb"};
    vt[14] = '{47,  64,  1'b1, 3'b111, 8'hD7, 8'hD7, 8'hD7, 1'b1, "above_window"};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 8'h00, 8'h00, 8'h00, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      scan_to(vt[i].y, vt[i].x, vt[i].dv, vt[i].brd);
      chk(vt[i].name, vt[i].er, vt[i].eg, vt[i].eb, vt[i].ede);
    end

    // Address scramble, checked combinationally mid-cycle.
    de = 1'b1;
    pix_y = 10'd68;  pix_x = 10'd96;  #2; chk_addr("addr_bmp_sy10", 13'h0223);
    pix_x = 10'd97;  #2;                  chk_addr("addr_att_sy10", 13'h1823);
    pix_y = 10'd178; pix_x = 10'd96;  #2; chk_addr("addr_bmp_sy65", 13'h0903);
    pix_x = 10'd97;  #2;                  chk_addr("addr_att_sy65", 13'h1903);
    pix_x = 10'd600; #2;                  chk_addr("addr_outside", 13'h0000);
    pix_x = 10'd96;  de = 1'b0; #2;       chk_addr("addr_de_low", 13'h0000);
    @(posedge clk);
    #1;

    // Flash cell at sy=8, col 0, across the frame counter's phases.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    scan_to(64, 64, 1'b1, 3'b000);
    chk("flash_frame0", 8'hD7, 8'hD7, 8'hD7, 1'b1);
    frames(15);
    scan_to(64, 64, 1'b1, 3'b000);
    chk("flash_frame15", 8'hD7, 8'hD7, 8'hD7, 1'b1);
    frames(1);
    scan_to(64, 64, 1'b1, 3'b000);
    chk("flash_frame16", FLASHED, FLASHED, FLASHED, 1'b1);
    frames(15);
    scan_to(64, 64, 1'b1, 3'b000);
    chk("flash_frame31", FLASHED, FLASHED, FLASHED, 1'b1);
    frames(1);
    scan_to(64, 64, 1'b1, 3'b000);
    chk("flash_frame32", 8'hD7, 8'hD7, 8'hD7, 1'b1);

    // Reset pulse mid-line inside a lit cell.
    scan_to(48, 300, 1'b1, 3'b010);
    chk("pre_reset_x300", 8'hFF, 8'hFF, 8'hFF, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("reset_async", 8'h00, 8'h00, 8'h00, 1'b0);
    step(48, 301, 1'b1);
    reset_n = 1'b1;
    step(48, 302, 1'b1);
    chk("post_reset_cur_clear", 8'h00, 8'h00, 8'h00, 1'b1);
    for (int x = 303; x <= 320; x++) step(48, x, 1'b1);
    chk("post_reset_next_cell_ink", 8'hFF, 8'hFF, 8'hFF, 1'b1);
    step(48, 321, 1'b1);
    step(48, 322, 1'b1);
    chk("post_reset_next_cell_paper", 8'h00, 8'h00, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
